tile_rst_irq_sequencer: RTL and testbench
=========================================

Name: tile_rst_irq_sequencer

Overview:
Per-tile reset sequencer and interrupt synchronizer between the tile reset/interrupt inputs and the core. It holds the core in reset while tile SRAMs initialise, can optionally wait for an L1.5 wake-up interrupt, and releases core reset through a configurable synchronizer chain. Asynchronous interrupt lines are synchronized and gated, and software-requested warm resets use a shortened count.

Parameters:
WAKE_CNT_W, 16, wake counter width; cold-boot count limit COLD_LIMIT = 2^(WAKE_CNT_W-1) cycles
SOFT_CNT, 64, warm-reset count limit in cycles; must be 1 to COLD_LIMIT
NUM_IRQ, 5, number of asynchronous interrupt lines (irq[1:0], ipi, timer, debug)
SYNC_STAGES, 2, flop stages per interrupt synchronizer; minimum 2
RST_STAGES, 2, flop stages in the core-reset release chain; minimum 2
WAKE_ON_IRQ, 0, 1 = after the cold count, wait for wake_val_i before release

Ports:
clk_i  in  1  clock
reset_l  in  1  asynchronous, active-low tile reset
irq_async_i  in  NUM_IRQ  asynchronous level interrupt inputs
wake_val_i  in  1  synchronous one-cycle pulse: L1.5 interrupt-type return valid
soft_rst_req_i  in  1  synchronous warm-reset request (level, sampled only in RUN)
spc_grst_l  out  1  core reset, active-low
irq_sync_o  out  NUM_IRQ  synchronized interrupts, gated by spc_grst_l
soft_rst_ack_o  out  1  one-cycle pulse: warm reset completed
state_o  out  2  FSM state (HOLD=00, COUNT=01, WAIT_WAKE=10, RUN=11)
wake_timeout_o  out  1  sticky wake-timeout flag (tied 0 unless macro enabled)

Behaviour:
- Reset (reset_l=0), all asynchronous: state=HOLD, cnt=0, warm flag=0, reset chain=0, all sync flops=0. Outputs: spc_grst_l=0, irq_sync_o=0, soft_rst_ack_o=0, state_o=00, wake_timeout_o=0.
- HOLD: cnt cleared to 0; goes to COUNT on the next edge.
- COUNT: cnt increments each cycle. Limit = SOFT_CNT if the warm flag is set, else COLD_LIMIT. When cnt==limit-1:
  - go to WAIT_WAKE if WAKE_ON_IRQ=1 and the warm flag is clear;
  - otherwise go to RUN.
  - COUNT therefore lasts exactly limit cycles. cnt never wraps.
- WAIT_WAKE: goes to RUN on the edge where wake_val_i=1. wake_val_i is ignored in all other states.
- RUN: reset chain shifts in 1 each cycle; spc_grst_l rises RST_STAGES cycles after entering RUN.
- Warm reset: in RUN with soft_rst_req_i=1:
  - set the warm flag and go to HOLD;
  - on the same edge the chain is cleared, so spc_grst_l=0 one cycle after the request is sampled;
  - soft_rst_req_i is ignored outside RUN.
- soft_rst_ack_o: one-cycle pulse in the cycle spc_grst_l rises while the warm flag is set; the warm flag clears on that same edge. It never pulses on cold boot.
- Warm reset skips WAIT_WAKE, because the core is already woken.
- Interrupt path:
  - each irq_async_i bit passes through SYNC_STAGES flops (latency SYNC_STAGES cycles);
  - irq_sync_o = sync_out AND spc_grst_l, so interrupts are forced to 0 while the core is in reset;
  - the sync flops keep running during HOLD and COUNT.
- reset_l asserted mid-operation (any state, including a warm count) returns immediately to the reset values above, and the warm flag clears. The next sequence is therefore a cold one.
- soft_rst_req_i held high continuously: the FSM re-enters HOLD each time the sequence reaches RUN. This gives one ack pulse per cycle through the loop, and spc_grst_l stays high for 1 cycle per loop.

Optional Feature:
TILE_WAKE_TIMEOUT_EN
- Defined:
  - in WAIT_WAKE, cnt restarts at 0 and increments;
  - if cnt reaches 2^WAKE_CNT_W-1 without wake_val_i, go to RUN and set wake_timeout_o=1, sticky until reset_l;
  - wake_val_i in the same cycle as the timeout takes priority and wake_timeout_o stays 0.
- Undefined: WAIT_WAKE waits indefinitely and wake_timeout_o is tied to 0.

Test Plan:
1. WAKE_CNT_W=4, RST_STAGES=2, WAKE_ON_IRQ=0; release reset_l -> state_o 00 for 1 cycle, 01 for 8 cycles, then 11; spc_grst_l rises 2 cycles after entering RUN; soft_rst_ack_o stays 0.
2. WAKE_ON_IRQ=1, wake_val_i pulsed 5 cycles after WAIT_WAKE entry -> state_o=10 for 5 cycles, RUN on the pulse edge; a wake_val_i pulse during COUNT has no effect.
3. SOFT_CNT=3, RUN, soft_rst_req_i pulsed for 1 cycle -> spc_grst_l=0 the next cycle; HOLD 1 cycle, COUNT 3 cycles, RUN (no WAIT_WAKE); spc_grst_l high after 2 cycles with a 1-cycle soft_rst_ack_o on the same cycle.
4. irq_async_i=5'b10101 during COUNT -> irq_sync_o=0; after spc_grst_l rises -> irq_sync_o=5'b10101; a single-bit toggle in RUN appears after exactly SYNC_STAGES=2 cycles.
5. reset_l asserted 2 cycles into a warm-reset COUNT -> all outputs at reset values immediately; after release, COUNT lasts 8 cycles (cold count) and no ack pulse occurs.
6. TILE_WAKE_TIMEOUT_EN, WAKE_CNT_W=4, WAKE_ON_IRQ=1, no wake_val_i -> RUN after 15 cycles in WAIT_WAKE, wake_timeout_o=1 and held high through a following warm reset.

Source files
------------

// File: rtl/tile_rst_irq_sequencer.sv
// rtl/tile_rst_irq_sequencer.sv - per-tile core reset sequencer and interrupt synchronizer
//
// Holds the core in reset while tile SRAMs initialise (cold count), optionally
// waits for an L1.5 wake-up return, then releases core reset through a
// RST_STAGES-deep chain. Software warm resets rerun the sequence with the
// shorter SOFT_CNT count and skip the wake wait.
//
// Optional feature macro: TILE_WAKE_TIMEOUT_EN (bounds the wake wait and
// drives a sticky wake_timeout_o; undefined -> wait forever, flag tied 0).
//
// Ports:
//   clk_i           clock
//   reset_l         asynchronous active-low tile reset
//   irq_async_i     asynchronous level interrupts [NUM_IRQ]
//   wake_val_i      one-cycle L1.5 interrupt-type return valid
//   soft_rst_req_i  warm-reset request level, honoured only in RUN
//   spc_grst_l      core reset, active-low
//   irq_sync_o      synchronized interrupts, forced 0 while core in reset
//   soft_rst_ack_o  one-cycle pulse when a warm reset releases the core
//   state_o         HOLD=00 COUNT=01 WAIT_WAKE=10 RUN=11
//   wake_timeout_o  sticky wake-timeout flag
module tile_rst_irq_sequencer #(
  parameter int WAKE_CNT_W  = 16,
  parameter int SOFT_CNT    = 64,
  parameter int NUM_IRQ     = 5,
  parameter int SYNC_STAGES = 2,
  parameter int RST_STAGES  = 2,
  parameter int WAKE_ON_IRQ = 0
) (
  input  logic               clk_i,
  input  logic               reset_l,
  input  logic [NUM_IRQ-1:0] irq_async_i,
  input  logic               wake_val_i,
  input  logic               soft_rst_req_i,
  output logic               spc_grst_l,
  output logic [NUM_IRQ-1:0] irq_sync_o,
  output logic               soft_rst_ack_o,
  output logic [1:0]         state_o,
  output logic               wake_timeout_o
);

  localparam int COLD_LIMIT = 1 << (WAKE_CNT_W - 1);
  localparam logic [WAKE_CNT_W-1:0] COLD_LAST = WAKE_CNT_W'(COLD_LIMIT - 1);
  localparam logic [WAKE_CNT_W-1:0] SOFT_LAST = WAKE_CNT_W'(SOFT_CNT - 1);
`ifdef TILE_WAKE_TIMEOUT_EN
  // Leaving on this value means the counter would reach all-ones on the edge.
  localparam logic [WAKE_CNT_W-1:0] WAIT_LAST = WAKE_CNT_W'((1 << WAKE_CNT_W) - 2);
`endif

  typedef enum logic [1:0] {
    ST_HOLD      = 2'b00,
    ST_COUNT     = 2'b01,
    ST_WAIT_WAKE = 2'b10,
    ST_RUN       = 2'b11
  } state_e;

  state_e                                state_q, state_d;
  logic [WAKE_CNT_W-1:0]                 cnt_q, cnt_d;
  logic [WAKE_CNT_W-1:0]                 cnt_last;
  logic                                  warm_q, warm_d;
  logic [RST_STAGES-1:0]                 chain_q, chain_d;
  logic                                  ack_q, ack_d;
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0]   sync_q, sync_d;
`ifdef TILE_WAKE_TIMEOUT_EN
  logic                                  timeout_q, timeout_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    warm_d   = warm_q;
    chain_d  = chain_q;
    ack_d    = 1'b0;
    cnt_last = warm_q ? SOFT_LAST : COLD_LAST;
    // Synchronizers run in every state; gating happens at the output.
    sync_d   = {sync_q[SYNC_STAGES-2:0], irq_async_i};
`ifdef TILE_WAKE_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_HOLD: begin
        cnt_d   = '0;
        state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (cnt_q == cnt_last) begin
          cnt_d = '0;
          // A warm reset finds the core already woken, so no wake wait.
          state_d = ((WAKE_ON_IRQ != 0) && !warm_q) ? ST_WAIT_WAKE : ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_WAKE: begin
`ifdef TILE_WAKE_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
        if (wake_val_i) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else if (cnt_q == WAIT_LAST) begin
          cnt_d     = '0;
          state_d   = ST_RUN;
          timeout_d = 1'b1;
        end
`else
        if (wake_val_i) begin
          state_d = ST_RUN;
        end
`endif
      end
      default: begin
        // A warm request is honoured once the core is out of reset, so a
        // held request still lets the core run for one cycle per loop.
        if (soft_rst_req_i && spc_grst_l) begin
          warm_d  = 1'b1;
          chain_d = '0;
          state_d = ST_HOLD;
        end else begin
          chain_d = {chain_q[RST_STAGES-2:0], 1'b1};
          if (chain_q[RST_STAGES-2] && !chain_q[RST_STAGES-1] && warm_q) begin
            ack_d  = 1'b1;
            warm_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      warm_q    <= 1'b0;
      chain_q   <= '0;
      ack_q     <= 1'b0;
      sync_q    <= '0;
`ifdef TILE_WAKE_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      warm_q    <= warm_d;
      chain_q   <= chain_d;
      ack_q     <= ack_d;
      sync_q    <= sync_d;
`ifdef TILE_WAKE_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  assign spc_grst_l     = chain_q[RST_STAGES-1];
  assign irq_sync_o     = sync_q[SYNC_STAGES-1] & {NUM_IRQ{spc_grst_l}};
  assign soft_rst_ack_o = ack_q;
  assign state_o        = state_q;
`ifdef TILE_WAKE_TIMEOUT_EN
  assign wake_timeout_o = timeout_q;
`else
  assign wake_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_tile_rst_irq_sequencer.sv
// tb/tb_tile_rst_irq_sequencer.sv - bench for tile_rst_irq_sequencer
module tb_tile_rst_irq_sequencer;

  localparam int COLD_P = 8;
  localparam int SOFT_P = 3;
  localparam int RST_P  = 2;
  localparam logic [1:0] S_HOLD = 2'b00, S_COUNT = 2'b01, S_WAIT = 2'b10, S_RUN = 2'b11;

  logic       clk_i = 1'b0;
  logic       reset_l = 1'b0;
  logic [4:0] irq_async = '0;
  logic       wake0 = 1'b0, soft0 = 1'b0, wake1 = 1'b0, soft1 = 1'b0;
  logic       grst0, ack0, to0, grst1, ack1, to1;
  logic [4:0] irq0, irq1;
  logic [1:0] st0, st1;

  int checks = 0;
  int errors = 0;

  // Interrupt values seen by the synchronizers at the last two edges.
  logic [4:0] h_cur = '0, h_prev = '0;

  // Expected per-cycle trace.
  logic [1:0] q_st[$];
  bit         q_gr[$];
  bit         q_ack[$];

  always #5 clk_i = ~clk_i;

  tile_rst_irq_sequencer #(.WAKE_CNT_W(4), .SOFT_CNT(3), .NUM_IRQ(5), .SYNC_STAGES(2),
                           .RST_STAGES(2), .WAKE_ON_IRQ(0)) dut0 (
    .clk_i(clk_i), .reset_l(reset_l), .irq_async_i(irq_async), .wake_val_i(wake0),
    .soft_rst_req_i(soft0), .spc_grst_l(grst0), .irq_sync_o(irq0),
    .soft_rst_ack_o(ack0), .state_o(st0), .wake_timeout_o(to0));

  tile_rst_irq_sequencer #(.WAKE_CNT_W(4), .SOFT_CNT(3), .NUM_IRQ(5), .SYNC_STAGES(2),
                           .RST_STAGES(2), .WAKE_ON_IRQ(1)) dut1 (
    .clk_i(clk_i), .reset_l(reset_l), .irq_async_i(irq_async), .wake_val_i(wake1),
    .soft_rst_req_i(soft1), .spc_grst_l(grst1), .irq_sync_o(irq1),
    .soft_rst_ack_o(ack1), .state_o(st1), .wake_timeout_o(to1));

  task automatic tick();
    logic [4:0] cur;
    cur = reset_l ? irq_async : 5'b0;
    @(posedge clk_i);
    #1;
    h_prev = h_cur;
    h_cur  = cur;
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    wake0 = 1'b0; soft0 = 1'b0; wake1 = 1'b0; soft1 = 1'b0;
    h_cur = '0; h_prev = '0;
    tick();
    tick();
    reset_l = 1'b1;
  endtask

  task automatic clear_trace();
    q_st.delete(); q_gr.delete(); q_ack.delete();
  endtask

  // Sequence from the spec rules: HOLD 1 cycle, COUNT limit cycles, optional
  // wake wait (cold only), then RUN with core reset lifting RST_P cycles in.
  task automatic build(input bit won, input bit warm, input bit with_hold,
                       input int wait_n, input int run_n);
    int limit;
    limit = warm ? SOFT_P : COLD_P;
    if (with_hold) begin
      q_st.push_back(S_HOLD); q_gr.push_back(1'b0); q_ack.push_back(1'b0);
    end
    for (int k = 0; k < limit; k++) begin
      q_st.push_back(S_COUNT); q_gr.push_back(1'b0); q_ack.push_back(1'b0);
    end
    if (won && !warm) begin
      for (int k = 0; k < wait_n; k++) begin
        q_st.push_back(S_WAIT); q_gr.push_back(1'b0); q_ack.push_back(1'b0);
      end
    end
    for (int k = 0; k < run_n; k++) begin
      q_st.push_back(S_RUN); q_gr.push_back(k >= RST_P); q_ack.push_back(warm && (k == RST_P));
    end
  endtask

  task automatic test_reset();
    do_reset();
    irq_async = 5'h1f;
    for (int i = 0; i < 12; i++) tick();
    reset_l = 1'b0;
    h_cur = '0; h_prev = '0;
    #1;
    checks++; if (st0 !== S_HOLD) begin errors++; $display("FAIL reset_st0 got %0d exp 0", st0); end
    checks++; if (grst0 !== 1'b0) begin errors++; $display("FAIL reset_grst0 got %0b exp 0", grst0); end
    checks++; if (irq0 !== 5'h0) begin errors++; $display("FAIL reset_irq0 got %0h exp 0", irq0); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0 got %0b exp 0", ack0); end
    checks++; if (to0 !== 1'b0) begin errors++; $display("FAIL reset_to0 got %0b exp 0", to0); end
    checks++; if (st1 !== S_HOLD) begin errors++; $display("FAIL reset_st1 got %0d exp 0", st1); end
    checks++; if (grst1 !== 1'b0) begin errors++; $display("FAIL reset_grst1 got %0b exp 0", grst1); end
    checks++; if (irq1 !== 5'h0) begin errors++; $display("FAIL reset_irq1 got %0h exp 0", irq1); end
    checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL reset_to1 got %0b exp 0", to1); end
    tick();
    reset_l = 1'b1;
    checks++; if (st0 !== S_HOLD) begin errors++; $display("FAIL release_st0 got %0d exp 0", st0); end
  endtask

  task automatic test_cold_boot();
    irq_async = 5'b10101;
    do_reset();
    checks++; if (st0 !== S_HOLD) begin errors++; $display("FAIL cold_hold got %0d exp 0", st0); end
    clear_trace();
    build(1'b0, 1'b0, 1'b0, 0, 6);
    for (int i = 0; i < q_st.size(); i++) begin
      tick();
      checks++; if (st0 !== q_st[i]) begin errors++; $display("FAIL cold_state i=%0d got %0d exp %0d", i, st0, q_st[i]); end
      checks++; if (grst0 !== q_gr[i]) begin errors++; $display("FAIL cold_grst i=%0d got %0b exp %0b", i, grst0, q_gr[i]); end
      checks++; if (ack0 !== q_ack[i]) begin errors++; $display("FAIL cold_ack i=%0d got %0b exp %0b", i, ack0, q_ack[i]); end
      checks++; if (irq0 !== (h_prev & {5{q_gr[i]}})) begin errors++; $display("FAIL cold_irq i=%0d got %0h exp %0h", i, irq0, h_prev & {5{q_gr[i]}}); end
    end
  endtask

  task automatic test_irq();
    for (int i = 0; i < 24; i++) begin
      int b;
      tick();
      checks++; if (grst0 !== 1'b1) begin errors++; $display("FAIL irq_grst i=%0d got %0b exp 1", i, grst0); end
      checks++; if (irq0 !== h_prev) begin errors++; $display("FAIL irq_lat i=%0d got %0h exp %0h", i, irq0, h_prev); end
      b = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) irq_async[b] = ~irq_async[b];
    end
  endtask

  task automatic test_warm();
    for (int it = 0; it < 3; it++) begin
      int idle;
      idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++) begin
        tick();
        checks++; if (st0 !== S_RUN || grst0 !== 1'b1 || ack0 !== 1'b0) begin
          errors++; $display("FAIL warm_idle it=%0d got st=%0d grst=%0b ack=%0b exp 3/1/0", it, st0, grst0, ack0);
        end
      end
      soft0 = 1'b1;
      clear_trace();
      build(1'b0, 1'b1, 1'b1, 0, RST_P + 1 + $urandom_range(0, 2));
      for (int i = 0; i < q_st.size(); i++) begin
        tick();
        soft0 = 1'b0;
        checks++; if (st0 !== q_st[i]) begin errors++; $display("FAIL warm_state it=%0d i=%0d got %0d exp %0d", it, i, st0, q_st[i]); end
        checks++; if (grst0 !== q_gr[i]) begin errors++; $display("FAIL warm_grst it=%0d i=%0d got %0b exp %0b", it, i, grst0, q_gr[i]); end
        checks++; if (ack0 !== q_ack[i]) begin errors++; $display("FAIL warm_ack it=%0d i=%0d got %0b exp %0b", it, i, ack0, q_ack[i]); end
        checks++; if (irq0 !== (h_prev & {5{q_gr[i]}})) begin errors++; $display("FAIL warm_irq i=%0d got %0h exp %0h", i, irq0, h_prev & {5{q_gr[i]}}); end
      end
    end
  endtask

  task automatic test_soft_held();
    soft0 = 1'b1;
    clear_trace();
    for (int l = 0; l < 3; l++) build(1'b0, 1'b1, 1'b1, 0, RST_P + 1);
    for (int i = 0; i < q_st.size(); i++) begin
      tick();
      checks++; if (st0 !== q_st[i]) begin errors++; $display("FAIL held_state i=%0d got %0d exp %0d", i, st0, q_st[i]); end
      checks++; if (grst0 !== q_gr[i]) begin errors++; $display("FAIL held_grst i=%0d got %0b exp %0b", i, grst0, q_gr[i]); end
      checks++; if (ack0 !== q_ack[i]) begin errors++; $display("FAIL held_ack i=%0d got %0b exp %0b", i, ack0, q_ack[i]); end
      soft0 = (i < q_st.size() - 1);
    end
  endtask

  task automatic test_reset_in_warm();
    soft0 = 1'b1;
    tick();
    soft0 = 1'b0;
    checks++; if (st0 !== S_HOLD) begin errors++; $display("FAIL rw_hold got %0d exp 0", st0); end
    tick();
    tick();
    checks++; if (st0 !== S_COUNT) begin errors++; $display("FAIL rw_count got %0d exp 1", st0); end
    reset_l = 1'b0;
    h_cur = '0; h_prev = '0;
    #1;
    checks++; if (st0 !== S_HOLD) begin errors++; $display("FAIL rw_rst_st got %0d exp 0", st0); end
    checks++; if (grst0 !== 1'b0) begin errors++; $display("FAIL rw_rst_grst got %0b exp 0", grst0); end
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL rw_rst_ack got %0b exp 0", ack0); end
    checks++; if (irq0 !== 5'h0) begin errors++; $display("FAIL rw_rst_irq got %0h exp 0", irq0); end
    tick();
    reset_l = 1'b1;
    clear_trace();
    build(1'b0, 1'b0, 1'b0, 0, RST_P + 3);
    for (int i = 0; i < q_st.size(); i++) begin
      tick();
      checks++; if (st0 !== q_st[i]) begin errors++; $display("FAIL rw_state i=%0d got %0d exp %0d", i, st0, q_st[i]); end
      checks++; if (grst0 !== q_gr[i]) begin errors++; $display("FAIL rw_grst i=%0d got %0b exp %0b", i, grst0, q_gr[i]); end
      checks++; if (ack0 !== q_ack[i]) begin errors++; $display("FAIL rw_ack i=%0d got %0b exp %0b", i, ack0, q_ack[i]); end
    end
  endtask

  task automatic test_wake();
    for (int it = 0; it < 3; it++) begin
      int d, p;
      d = (it == 0) ? 15 : $urandom_range(1, 14);
      p = $urandom_range(0, COLD_P - 1);
      irq_async = 5'($urandom);
      do_reset();
      checks++; if (st1 !== S_HOLD) begin errors++; $display("FAIL wake_hold it=%0d got %0d exp 0", it, st1); end
      clear_trace();
      build(1'b1, 1'b0, 1'b0, d, RST_P + 2);
      for (int i = 0; i < q_st.size(); i++) begin
        tick();
        checks++; if (st1 !== q_st[i]) begin errors++; $display("FAIL wake_state it=%0d i=%0d got %0d exp %0d", it, i, st1, q_st[i]); end
        checks++; if (grst1 !== q_gr[i]) begin errors++; $display("FAIL wake_grst it=%0d i=%0d got %0b exp %0b", it, i, grst1, q_gr[i]); end
        checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL wake_ack it=%0d i=%0d got %0b exp 0", it, i, ack1); end
        checks++; if (irq1 !== (h_prev & {5{q_gr[i]}})) begin errors++; $display("FAIL wake_irq i=%0d got %0h exp %0h", i, irq1, h_prev & {5{q_gr[i]}}); end
        checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL wake_to it=%0d i=%0d got %0b exp 0", it, i, to1); end
        wake1 = (i == p) || (i == COLD_P - 1 + d);
      end
      wake1 = 1'b0;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    checks++; if (st1 !== S_HOLD) begin errors++; $display("FAIL to_hold got %0d exp 0", st1); end
    clear_trace();
`ifdef TILE_WAKE_TIMEOUT_EN
    build(1'b1, 1'b0, 1'b0, 15, RST_P + 1);
    for (int i = 0; i < q_st.size(); i++) begin
      tick();
      checks++; if (st1 !== q_st[i]) begin errors++; $display("FAIL to_state i=%0d got %0d exp %0d", i, st1, q_st[i]); end
      checks++; if (grst1 !== q_gr[i]) begin errors++; $display("FAIL to_grst i=%0d got %0b exp %0b", i, grst1, q_gr[i]); end
      checks++; if (to1 !== (q_st[i] == S_RUN)) begin errors++; $display("FAIL to_flag i=%0d got %0b exp %0b", i, to1, q_st[i] == S_RUN); end
    end
    soft1 = 1'b1;
    clear_trace();
    build(1'b1, 1'b1, 1'b1, 0, RST_P + 1);
    for (int i = 0; i < q_st.size(); i++) begin
      tick();
      soft1 = 1'b0;
      checks++; if (st1 !== q_st[i]) begin errors++; $display("FAIL to_warm_state i=%0d got %0d exp %0d", i, st1, q_st[i]); end
      checks++; if (ack1 !== q_ack[i]) begin errors++; $display("FAIL to_warm_ack i=%0d got %0b exp %0b", i, ack1, q_ack[i]); end
      checks++; if (to1 !== 1'b1) begin errors++; $display("FAIL to_sticky i=%0d got %0b exp 1", i, to1); end
    end
`else
    build(1'b1, 1'b0, 1'b0, 32, 0);
    for (int i = 0; i < q_st.size(); i++) begin
      tick();
      checks++; if (st1 !== q_st[i]) begin errors++; $display("FAIL nto_state i=%0d got %0d exp %0d", i, st1, q_st[i]); end
      checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL nto_flag i=%0d got %0b exp 0", i, to1); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_boot();
    test_irq();
    test_warm();
    test_soft_held();
    test_reset_in_warm();
    test_wake();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
